// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage 16-bit MIPS pipeline.
// Arbitrates memory freeze, branch flush and load-use stall; keeps debug counters and a watchdog.
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = 3,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              branch_taken,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_src,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_flush,
    output logic              pipe_hold,
    output logic [1:0]        action,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  freeze_count,
    output logic              mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } action_e;

    action_e           act;
    logic              lu;
    logic [WAIT_W-1:0] wait_cnt;

    // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign lu = ex_mem_read & id_valid & (ex_rt != '0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_comb begin
        if (!mem_ready)        act = ACT_FREEZE;
        else if (branch_taken) act = ACT_FLUSH;
        else if (lu)           act = ACT_STALL;
        else                   act = ACT_RUN;
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;
        action       = act;
        if (!reset_n) begin
            // Fill the pipeline with NOPs while reset is held.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            action       = ACT_RUN;
        end else begin
            unique case (act)
                ACT_RUN: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
                ACT_STALL: id_ex_bubble = 1'b1;
                ACT_FLUSH: begin
                    pc_write     = 1'b1;
                    pc_src       = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                end
                ACT_FREEZE: pipe_hold = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else begin
            if (act == ACT_STALL && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (act == ACT_FLUSH && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
            if (act == ACT_FREEZE && freeze_count != '1)
                freeze_count <= freeze_count + CNT_W'(1);
        end
    end

    // Watchdog: wait_cnt tracks consecutive freeze cycles; the flag is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (act == ACT_FREEZE) begin
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST)
                mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle model compare plus literal checkpoints.
// A second instance with narrow counters exercises saturation.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int CW2      = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic       branch_taken = 1'b0, mem_ready = 1'b1;
    logic [2:0] id_rs = '0, id_rt = '0, ex_rt = '0;

    logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold;
    logic [1:0]  action;
    logic [15:0] stall_count, flush_count, freeze_count;
    logic        mem_timeout;

    logic        pc_write2, pc_src2, if_id_write2, if_id_flush2, id_ex_bubble2, ex_mem_flush2, pipe_hold2;
    logic [1:0]  action2;
    logic [CW2-1:0] stall_count2, flush_count2, freeze_count2;
    logic        mem_timeout2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(3), .CNT_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
        .action(action), .stall_count(stall_count), .flush_count(flush_count),
        .freeze_count(freeze_count), .mem_timeout(mem_timeout)
    );

    pipeline_hazard_ctrl #(.REG_AW(3), .CNT_W(CW2), .MAX_WAIT(MAX_WAIT)) dut2 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_write(pc_write2), .pc_src(pc_src2), .if_id_write(if_id_write2), .if_id_flush(if_id_flush2),
        .id_ex_bubble(id_ex_bubble2), .ex_mem_flush(ex_mem_flush2), .pipe_hold(pipe_hold2),
        .action(action2), .stall_count(stall_count2), .flush_count(flush_count2),
        .freeze_count(freeze_count2), .mem_timeout(mem_timeout2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int decide();
        bit hz;
        hz = ex_mem_read && id_valid && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        if (!mem_ready) return 3;
        if (branch_taken) return 2;
        if (hz) return 1;
        return 0;
    endfunction

    // {pc_write,pc_src,if_id_write,if_id_flush,id_ex_bubble,ex_mem_flush,pipe_hold,action[1:0]}
    function automatic logic [8:0] exp_ctrl();
        if (!reset_n) return 9'b0_0_0_1_1_1_0_00;
        case (decide())
            0: return 9'b1_0_1_0_0_0_0_00;
            1: return 9'b0_0_0_0_1_0_0_01;
            2: return 9'b1_1_1_1_1_1_0_10;
            default: return 9'b0_0_0_0_0_0_1_11;
        endcase
    endfunction

    // Unbounded event totals; each DUT shows them clipped to its own counter width.
    int m_stall = 0, m_flush = 0, m_freeze = 0, m_consec = 0;
    bit m_tmo = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stall = 0; m_flush = 0; m_freeze = 0; m_consec = 0; m_tmo = 0;
        end else begin
            case (decide())
                1: m_stall++;
                2: m_flush++;
                3: m_freeze++;
                default: ;
            endcase
            if (decide() == 3) begin
                m_consec++;
                if (m_consec >= MAX_WAIT) m_tmo = 1;
            end else m_consec = 0;
        end
    end

    function automatic int clip(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        chk("ctrl", {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
                     pipe_hold, action}, exp_ctrl());
        chk("ctrl2", {pc_write2, pc_src2, if_id_write2, if_id_flush2, id_ex_bubble2, ex_mem_flush2,
                      pipe_hold2, action2}, exp_ctrl());
        chk("stall_count", stall_count, clip(m_stall, 16));
        chk("flush_count", flush_count, clip(m_flush, 16));
        chk("freeze_count", freeze_count, clip(m_freeze, 16));
        chk("mem_timeout", mem_timeout, m_tmo);
        chk("stall_count2", stall_count2, clip(m_stall, CW2));
        chk("flush_count2", flush_count2, clip(m_flush, CW2));
        chk("freeze_count2", freeze_count2, clip(m_freeze, CW2));
        chk("mem_timeout2", mem_timeout2, m_tmo);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                       input logic mr, input logic [2:0] ert, input logic br, input logic rdy);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rt = ert; branch_taken = br; mem_ready = rdy;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        tick(); tick();
        chk("rst_stall", stall_count, 0);
        chk("rst_flush_out", if_id_flush, 1);
        chk("rst_pc_write", pc_write, 0);

        reset_n = 1'b1;
        drv(1, 1, 2, 1, 0, 0, 0, 1);
        tick();

        // load r3, consumer reads rs=3
        drv(1, 3, 4, 1, 1, 3, 0, 1);
        #2;
        chk("lu_action", action, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_bubble", id_ex_bubble, 1);
        tick();
        drv(1, 1, 2, 1, 0, 0, 0, 1);
        chk("lu_stall_count", stall_count, 1);
        tick();

        drv(1, 0, 0, 1, 1, 0, 0, 1);          // load to r0
        #2; chk("r0_no_stall", action, 0);
        tick();
        drv(1, 2, 5, 0, 1, 5, 0, 1);          // rt match but rt unused
        #2; chk("rt_unused", action, 0);
        tick();
        drv(1, 2, 5, 1, 1, 5, 0, 1);          // rt match and used
        #2; chk("rt_used", action, 1);
        tick();
        drv(0, 5, 5, 1, 1, 5, 0, 1);          // bubble in ID
        #2; chk("id_invalid", action, 0);
        tick();
        chk("stall2_pre_sat", stall_count2, 2);

        // branch together with load-use
        drv(1, 3, 0, 1, 1, 3, 1, 1);
        #2;
        chk("br_lu_action", action, 2);
        chk("br_lu_pc_src", pc_src, 1);
        chk("br_lu_exflush", ex_mem_flush, 1);
        tick();
        chk("br_flush_count", flush_count, 1);
        chk("br_stall_kept", stall_count, 2);

        for (int i = 0; i < 3; i++) begin
            drv(1, 3'(i + 1), 0, 0, 1, 3'(i + 1), 0, 1);
            tick();
        end
        chk("stall_five", stall_count, 5);
        chk("stall2_sat", stall_count2, 3);
        drv(1, 1, 2, 1, 0, 0, 0, 1);
        tick();

        // 20-cycle memory wait with a pending branch and hazard
        drv(1, 3, 0, 1, 1, 3, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            #2; chk("frz_hold", pipe_hold, 1);
            tick();
            if (k == 14) chk("tmo_before", mem_timeout, 0);
            if (k == 15) chk("tmo_at15", mem_timeout, 1);
        end
        drv(1, 3, 0, 1, 1, 3, 1, 1);
        #2;
        chk("post_frz_flush", action, 2);
        chk("frz_count20", freeze_count, 20);
        chk("tmo_sticky", mem_timeout, 1);
        tick();
        chk("flush_count2x", flush_count, 2);
        drv(1, 1, 2, 1, 0, 0, 0, 1);
        tick();
        chk("tmo_sticky_run", mem_timeout, 1);

        // reset in the middle of another freeze
        drv(1, 1, 2, 1, 0, 0, 0, 0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall_count, 0);
        chk("mid_rst_flush", flush_count, 0);
        chk("mid_rst_freeze", freeze_count, 0);
        chk("mid_rst_tmo", mem_timeout, 0);
        chk("mid_rst_ctrl", {pc_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold, action},
            7'b0_1_1_1_0_00);
        tick(); tick();
        reset_n = 1'b1;
        drv(1, 1, 2, 1, 0, 0, 0, 1);
        tick();
        chk("post_rst_freeze", freeze_count, 0);
        drv(1, 4, 0, 0, 1, 4, 0, 1);
        tick();
        chk("post_rst_stall", stall_count, 1);
        drv(1, 1, 2, 1, 0, 0, 0, 1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 16-bit five-stage MIPS pipeline. It sits beside the Fetch/IF_ID/Decode/ID_EX/EX_MEM/MEM_WB chain and drives the PC write enable, pipeline-register write enables, flushes and bubbles. It arbitrates between three competing conditions:
- memory-wait freeze;
- taken-branch flush;
- load-use stall.

It also keeps saturating event counters and a sticky memory-timeout watchdog for debug.

## Interface
Parameters:
- REG_AW, 3: register-address width (8 registers; register 0 hardwired to zero).
- CNT_W, 16: width of each event counter.
- MAX_WAIT, 15: consecutive memory-wait cycles before `mem_timeout` is set.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF_ID holds a real instruction (not a bubble).
- id_rs  in  REG_AW  rs field of the instruction in ID (instruction[11:9]).
- id_rt  in  REG_AW  rt field of the instruction in ID (instruction[8:6]).
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rt  in  REG_AW  destination register of the load in EX.
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- mem_ready  in  1  data memory can complete this cycle.
- pc_write  out  1  PC register load enable.
- pc_src  out  1  selects the branch target for the PC.
- if_id_write  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID loads a NOP.
- id_ex_bubble  out  1  ID_EX loads zeroed control signals.
- ex_mem_flush  out  1  EX_MEM loads zeroed control signals.
- pipe_hold  out  1  freezes ID_EX, EX_MEM and MEM_WB.
- action  out  2  current decision: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
- stall_count  out  CNT_W  number of load-use stall cycles.
- flush_count  out  CNT_W  number of branch flushes.
- freeze_count  out  CNT_W  number of memory-wait cycles.
- mem_timeout  out  1  sticky watchdog flag.

## Operation
- Load-use hazard (`lu`) = `ex_mem_read & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`.
- Decision is combinational from the current inputs. Priority, highest first:
  - FREEZE if `!mem_ready`;
  - else FLUSH if `branch_taken`;
  - else STALL if `lu`;
  - else RUN.
- Outputs per decision (every output not listed is 0):
  - RUN: `pc_write`=1, `if_id_write`=1.
  - STALL: `id_ex_bubble`=1. PC and IF_ID hold; EX/MEM/WB advance.
  - FLUSH: `pc_write`=1, `pc_src`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_bubble`=1, `ex_mem_flush`=1. The three younger instructions are discarded.
  - FREEZE: `pipe_hold`=1. PC and IF_ID also hold. No flush or bubble is issued, even if `branch_taken` or `lu` is set; those conditions are re-evaluated once `mem_ready` returns.
- Registered state, updated on the rising edge:
  - stall_count, flush_count and freeze_count each increment by 1 in a cycle whose action matches. Each saturates at 2^CNT_W−1 (no wrap).
  - wait_cnt (internal, 0..MAX_WAIT) increments during each FREEZE cycle, saturating at MAX_WAIT. It clears to 0 in any non-FREEZE cycle.
  - mem_timeout is set at the edge where a FREEZE cycle occurs while wait_cnt == MAX_WAIT−1, i.e. after the MAX_WAIT-th consecutive wait cycle. It stays set until reset and never affects the pipeline outputs.
- Reset (`reset_n`=0, asynchronous):
  - Counters, wait_cnt and mem_timeout clear to 0 immediately.
  - While reset is held, combinational outputs are forced: `pc_write`=0, `pc_src`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_bubble`=1, `ex_mem_flush`=1, `pipe_hold`=0, `action`=0. The pipeline therefore fills with NOPs.
  - Reset asserted mid-FREEZE or mid-STALL abandons that state. Counting restarts from 0 at the first edge after release.

## Timing
- Control outputs have zero-cycle latency: they are valid in the same cycle as their inputs and are consumed at the next rising edge.
- A load-use stall lasts exactly one cycle: after one bubble the load has moved to MEM, so `lu` deasserts. A back-to-back second hazard against a new load produces a new one-cycle stall.
- A flush occupies one cycle. In the following cycle EX holds a bubble, so `ex_mem_read`=0 and no stall can follow the flush.
- A branch and a hazard in the same cycle produce FLUSH only, and stall_count does not increment.
- `mem_ready`=0 together with `branch_taken`=1 produces FREEZE. When `mem_ready` rises, FLUSH follows in that same cycle if `branch_taken` is still asserted.
- Counter and flag updates become visible one cycle after the triggering action.

## Test plan
- Load `r3`, next instruction reads `id_rs`=3 with `id_valid`=1, `mem_ready`=1 -> one cycle with action=1, `pc_write`=0, `id_ex_bubble`=1; stall_count=1 on the next cycle.
- `ex_rt`=0 with `ex_mem_read`=1 and `id_rs`=0 -> action=0, no stall. Likewise `id_uses_rt`=0 with only an rt match -> no stall.
- `branch_taken`=1 together with `lu`=1 -> action=2, `pc_src`=1, all three flushes/bubbles=1; flush_count=1, stall_count unchanged.
- `mem_ready`=0 for 20 cycles with `branch_taken`=1 -> `pipe_hold`=1 throughout and no flush. mem_timeout rises after cycle 15 and remains 1 after `mem_ready` returns. freeze_count=20. FLUSH occurs on the first ready cycle.
- Force stall_count to 0xFFFE, then apply 3 stalls -> stall_count stays at 0xFFFF.
- Assert `reset_n`=0 in the middle of a freeze with mem_timeout=1 -> all counters and mem_timeout read 0 immediately. Outputs show `if_id_flush`=1, `id_ex_bubble`=1, `ex_mem_flush`=1, `pc_write`=0 until release.
